// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one downstream DMI port between NumReq upstream requesters.
//
// Round-robin grant, one outstanding transaction at a time. The downstream response is
// routed back to the owner of the transaction only. Any upstream clear aborts the
// outstanding transaction and is forwarded downstream.
//
// Optional feature (macro DMI_ARB_TIMEOUT_EN): watchdog counter over REQ and RESP. On expiry
// the owner receives an error response (resp=2'h2, data=0). A response that arrives after a
// timeout is sunk and not forwarded.
//
// Ports:
//   clk, rst_i                          clock, asynchronous active-high reset
//   dmi_clear_i[NumReq]                 per-requester clear
//   dmi_req_i / _valid_i / _ready_o     upstream request channels (41-bit requests)
//   dmi_resp_o / _valid_o / _ready_i    upstream response channels (34-bit responses)
//   dmi_clear_o                         downstream clear (OR of all upstream clears)
//   dmi_req_o / _valid_o / _ready_i     downstream request (registered)
//   dmi_resp_i / _valid_i / _ready_o    downstream response
//
// Request layout  {addr[6:0], op[1:0], data[31:0]}; response layout {data[31:0], resp[1:0]}.
module dmi_arbiter #(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        dmi_clear_i,
  input  logic [NumReq-1:0][40:0]  dmi_req_i,
  input  logic [NumReq-1:0]        dmi_req_valid_i,
  output logic [NumReq-1:0]        dmi_req_ready_o,
  output logic [NumReq-1:0][33:0]  dmi_resp_o,
  output logic [NumReq-1:0]        dmi_resp_valid_o,
  input  logic [NumReq-1:0]        dmi_resp_ready_i,
  output logic                     dmi_clear_o,
  output logic [40:0]              dmi_req_o,
  output logic                     dmi_req_valid_o,
  input  logic                     dmi_req_ready_i,
  input  logic [33:0]              dmi_resp_i,
  input  logic                     dmi_resp_valid_i,
  output logic                     dmi_resp_ready_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  if (NumReq < 2 || TimeoutCyc == 0) begin : g_param_check
    $error("dmi_arbiter: NumReq must be >= 2 and TimeoutCyc must be non-zero");
  end

`ifdef DMI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
`endif

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [40:0]       req_q, req_d;
  logic              any_clear;
  logic              grant_found;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand;

`ifdef DMI_ARB_TIMEOUT_EN
  logic [15:0]       cnt_q, cnt_d;
  logic              stale_q, stale_d;
  logic              timeout;
  assign timeout = (cnt_q == 16'(TimeoutCyc - 1));
`endif

  assign any_clear       = |dmi_clear_i;
  assign dmi_clear_o     = any_clear;
  assign dmi_req_o       = req_q;
  assign dmi_req_valid_o = (state_q == StReq);

  // Round-robin search starting at rr_ptr, wrapping at NumReq-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NumReq);
      if (!grant_found && dmi_req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    req_d            = req_q;
    dmi_req_ready_o  = '0;
    dmi_resp_o       = '0;
    dmi_resp_valid_o = '0;
    dmi_resp_ready_o = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
    cnt_d            = cnt_q;
    stale_d          = stale_q;
    // A response left over from a timed-out transaction is drained in any state.
    if (stale_q) begin
      dmi_resp_ready_o = 1'b1;
      if (dmi_resp_valid_i) stale_d = 1'b0;
    end
`endif

    unique case (state_q)
      StIdle: begin
        // Clear wins over a same-cycle grant.
        if (!any_clear && grant_found) begin
          dmi_req_ready_o[grant_idx] = 1'b1;
          req_d    = dmi_req_i[grant_idx];
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = StReq;
`ifdef DMI_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StReq: begin
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
        if (dmi_req_ready_i)  state_d = StResp;
        else if (timeout)     state_d = StErr;
`else
        if (dmi_req_ready_i)  state_d = StResp;
`endif
      end
      StResp: begin
        dmi_resp_o[owner_q] = dmi_resp_i;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
        dmi_resp_valid_o[owner_q] = dmi_resp_valid_i & ~any_clear & ~stale_q;
        dmi_resp_ready_o = dmi_resp_ready_i[owner_q] | any_clear | stale_q;
        if (dmi_resp_valid_i && dmi_resp_ready_o && !stale_q) begin
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StErr;
          stale_d = 1'b1;
        end
`else
        dmi_resp_valid_o[owner_q] = dmi_resp_valid_i & ~any_clear;
        // During a clear the response is sunk so downstream can drain.
        dmi_resp_ready_o = dmi_resp_ready_i[owner_q] | any_clear;
        if (dmi_resp_valid_i && dmi_resp_ready_o) state_d = StIdle;
`endif
      end
`ifdef DMI_ARB_TIMEOUT_EN
      StErr: begin
        dmi_resp_valid_o[owner_q] = ~any_clear;
        dmi_resp_o[owner_q]       = {32'h0, 2'h2};
        if (dmi_resp_ready_i[owner_q]) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (any_clear) begin
      state_d = StIdle;
`ifdef DMI_ARB_TIMEOUT_EN
      stale_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      req_q    <= '0;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      stale_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= req_d;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      stale_q  <= stale_d;
`endif
    end
  end

endmodule
